// File: rtl/btd_pkg.sv
// Shared definitions for the binary-to-BCD converter block.
// Contents:
//   state_t     - converter FSM states (IDLE, CONV, FIN)
//   DIGIT_W     - width of one BCD digit
//   ADD3_THRESH - a digit at or above this value gets ADD3_VAL before the shift
//   ADD3_VAL    - double-dabble correction amount
//   BCD_NINE    - digit value used to build the saturated result
package btd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;
  localparam logic [3:0] BCD_NINE    = 4'd9;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: every BCD digit >= 5 gets +3, then
// the {bcd, bin} concatenation shifts left by one bit.
// Ports:
//   i_bcd   [4*DIGITS-1:0] working BCD value
//   i_bin   [N-1:0]        working binary value (MSB is consumed next)
//   o_bcd   [4*DIGITS-1:0] corrected and shifted BCD value
//   o_bin   [N-1:0]        shifted binary value (zero enters at bit 0)
//   o_carry                bit shifted out of the top digit (overflow indicator)
module bcd_dabble_step
  import btd_pkg::*;
#(
  parameter int N      = 20,
  parameter int DIGITS = 6
) (
  input  logic [DIGIT_W*DIGITS-1:0] i_bcd,
  input  logic [N-1:0]              i_bin,
  output logic [DIGIT_W*DIGITS-1:0] o_bcd,
  output logic [N-1:0]              o_bin,
  output logic                      o_carry
);

  logic [DIGIT_W*DIGITS-1:0] w_corr;

  // Correction stays inside each 4-bit digit; the largest corrected value
  // is 9+3=12, so no carry ever crosses into the neighbouring digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [DIGIT_W-1:0] w_d;
    assign w_d = i_bcd[g*DIGIT_W +: DIGIT_W];
    assign w_corr[g*DIGIT_W +: DIGIT_W] = (w_d >= ADD3_THRESH) ? (w_d + ADD3_VAL) : w_d;
  end

  assign o_carry = w_corr[DIGIT_W*DIGITS-1];
  assign o_bcd   = {w_corr[DIGIT_W*DIGITS-2:0], i_bin[N-1]};
  assign o_bin   = {i_bin[N-2:0], 1'b0};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Sequential binary-to-BCD converter shared by two requesters with
// round-robin arbitration. A conversion takes N shift steps followed by one
// result cycle; the result is held until the next conversion completes.
// Values >= 10^DIGITS saturate to all nines and raise overflow.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   req[1:0]   request per requester; held with bin_k stable until ack[k]
//   bin0, bin1 binary operands of requester 0 / 1
//   ack[1:0]   one-cycle pulse: request k was captured
//   busy       conversion in progress (CONV or FIN)
//   done       one-cycle pulse: bcd_out/done_id/overflow updated
//   done_id    requester served by the latest result
//   bcd_out    packed BCD result, digit 0 in bits [3:0]
//   overflow   latest result did not fit in DIGITS digits
//   dbg_state  current FSM state (state_t encoding) for observation
//
// Handshake: a requester raises req[k] with bin_k stable and keeps both until
// it sees ack[k]; the value is sampled on the edge before the ack pulse, so
// bin_k may change from the ack cycle on. Dropping req[k] before ack
// withdraws the request. Requests are only looked at while IDLE.
module bcd_conv_arbiter
  import btd_pkg::*;
#(
  parameter int N      = 20,
  parameter int DIGITS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req,
  input  logic [N-1:0]              bin0,
  input  logic [N-1:0]              bin1,
  output logic [1:0]                ack,
  output logic                      busy,
  output logic                      done,
  output logic                      done_id,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      overflow,
  output logic [1:0]                dbg_state
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BCD_W-1:0] BCD_SAT = {DIGITS{BCD_NINE}};

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_last;
  logic             r_id;

  logic             w_grant;
  logic             w_pick;
  logic             w_last_step;
  logic [N-1:0]     w_bin_nxt;
  logic [BCD_W-1:0] w_bcd_nxt;
  logic             w_carry;
  logic             w_ovf_nxt;

  bcd_dabble_step #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_step (
    .i_bcd   (r_bcd),
    .i_bin   (r_bin),
    .o_bcd   (w_bcd_nxt),
    .o_bin   (w_bin_nxt),
    .o_carry (w_carry)
  );

  assign w_last_step = (r_cnt == CNT_W'(N - 1));
  assign w_ovf_nxt   = r_ovf | w_carry;
  assign busy        = (r_state != IDLE);
  assign dbg_state   = r_state;

  // Next state and arbitration. On a tie the requester that was not served
  // last wins; a single requester always wins.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_pick  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_grant = 1'b1;
          w_pick  = (req == 2'b11) ? ~r_last : req[1];
          w_next  = CONV;
        end
      end
      CONV:    if (w_last_step) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Datapath and registered outputs. The result is registered on the edge
  // that performs the final shift, so done is high during the FIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      ack      <= 2'b00;
      done     <= 1'b0;
      done_id  <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      ack  <= 2'b00;
      done <= 1'b0;
      if (w_grant) begin
        r_bin  <= w_pick ? bin1 : bin0;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        r_last <= w_pick;
        r_id   <= w_pick;
        ack    <= w_pick ? 2'b10 : 2'b01;
      end else if (r_state == CONV) begin
        r_bin <= w_bin_nxt;
        r_bcd <= w_bcd_nxt;
        r_ovf <= w_ovf_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last_step) begin
          done     <= 1'b1;
          bcd_out  <= w_ovf_nxt ? BCD_SAT : w_bcd_nxt;
          overflow <= w_ovf_nxt;
          done_id  <= r_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: a driver issues requests and pushes the
// hand-computed result into exp_q; a monitor pops and compares on every done.
module tb_bcd_conv_arbiter;

  localparam int N      = 20;
  localparam int DIGITS = 6;
  localparam int BCD_W  = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [N-1:0]     bin0 = '0;
  logic [N-1:0]     bin1 = '0;
  logic [1:0]       ack;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [BCD_W-1:0] bcd_out;
  logic             overflow;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_conv_arbiter #(.N(N), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin0      (bin0),
    .bin1      (bin1),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // entry = {id, ovf, bcd}
  logic [BCD_W+1:0] exp_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_err++;
        n_cmp++;
        $display("FAIL unexpected_done: got done=1 id=%0d bcd=0x%0h, expected no result", done_id, bcd_out);
      end else begin
        logic [BCD_W+1:0] e;
        e = exp_q.pop_front();
        check("bcd_out",  64'(bcd_out),  64'(e[BCD_W-1:0]));
        check("overflow", 64'(overflow), 64'(e[BCD_W]));
        check("done_id",  64'(done_id),  64'(e[BCD_W+1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  int cap_cyc;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},      64'(ack),       64'(0));
    check({tag, "_busy"},     64'(busy),      64'(0));
    check({tag, "_done"},     64'(done),      64'(0));
    check({tag, "_done_id"},  64'(done_id),   64'(0));
    check({tag, "_bcd_out"},  64'(bcd_out),   64'(0));
    check({tag, "_overflow"}, 64'(overflow),  64'(0));
    check({tag, "_state"},    64'(dbg_state), 64'(0));
  endtask

  // Raise req[k] with value v, wait for ack, push the expected result,
  // drop req and replace bin_k with v_after (must not affect the result).
  task automatic issue(input int k, input logic [N-1:0] v, input logic [BCD_W-1:0] eb,
                       input logic eo, input logic [N-1:0] v_after);
    bit got;
    @(negedge clk);
    if (k == 0) bin0 = v; else bin1 = v;
    req[k] = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout: got no ack in 40 cycles, expected ack[%0d]", k);
    end else begin
      exp_q.push_back({k[0], eo, eb});
      cap_cyc = cyc;
      check("ack_onehot", 64'(ack), 64'(1 << k));
      check("busy_conv",  64'(busy), 64'(1));
    end
    req[k] = 1'b0;
    if (k == 0) bin0 = v_after; else bin1 = v_after;
    @(negedge clk);
    check("ack_width", 64'(ack), 64'(0));
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int d_cyc[4];
    int saved;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // bin0 = 0, with latency measurement: done is N edges after the capture edge
    issue(0, 20'd0, 24'h000000, 1'b0, 20'd0);
    wait_done(60, ok);
    if (ok) check("latency", 64'(cyc - cap_cyc), 64'(N));
    @(negedge clk);
    check("done_width", 64'(done), 64'(0));

    // 123456; bin0 changes after ack, result must still be 123456 and held
    issue(0, 20'd123456, 24'h123456, 1'b0, 20'd777);
    wait_done(60, ok);
    repeat (6) @(negedge clk);
    check("hold_bcd", 64'(bcd_out), 64'h123456);
    check("idle_busy", 64'(busy), 64'(0));

    // requester 1, largest value that fits
    issue(1, 20'd999999, 24'h999999, 1'b0, 20'd0);
    wait_done(60, ok);
    @(negedge clk);

    // overflow saturates
    issue(0, 20'd1048575, 24'h999999, 1'b1, 20'd0);
    wait_done(60, ok);
    @(negedge clk);

    // Both requesters continuously from reset: strict alternation, 22 cycles apart
    rst  = 1'b1;
    req  = 2'b11;
    bin0 = 20'd42;
    bin1 = 20'd7;
    exp_q.push_back({1'b0, 1'b0, 24'h000042});
    exp_q.push_back({1'b1, 1'b0, 24'h000007});
    exp_q.push_back({1'b0, 1'b0, 24'h000042});
    exp_q.push_back({1'b1, 1'b0, 24'h000007});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wait_done(60, ok);
      d_cyc[i] = cyc;
      if (i > 0) check("rr_spacing", 64'(d_cyc[i] - d_cyc[i-1]), 64'(N + 2));
    end
    req = 2'b00;
    repeat (4) @(negedge clk);
    check("rr_no_extra", 64'(busy), 64'(0));

    // Reset during CONV cycle 10 aborts the conversion
    issue(0, 20'd999, 24'h000999, 1'b0, 20'd0);
    repeat (8) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    saved = n_done;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", 64'(n_done), 64'(saved));

    // Conversion after the abort
    issue(0, 20'd5, 24'h000005, 1'b0, 20'd0);
    wait_done(60, ok);
    repeat (3) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
